ibutterfly2: RTL
================

IBUTTERFLY2 -- requirements
Module: ibutterfly2

Inverse-direction radix-2 butterfly: decimation-in-frequency, conjugate twiddle, pipelined with valid tracking.

Interface
REQ-001 Parameter: N, default 16, total sample/twiddle width in two's complement.
REQ-002 Parameter: Q, default 15, fractional bits of all samples and twiddles.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operands valid this cycle; accepted unconditionally, no backpressure.
REQ-007 in0_r, in0_i, in1_r, in1_i  input  N each  operands a, b (signed).
REQ-008 twiddle_r, twiddle_i  input  N each  twiddle W, applied as conj(W).
REQ-009 scale  input  1  sampled with operands; 1 = divide stage result by 2.
REQ-010 ovf_clr  input  1  clears sticky overflow flag.
REQ-011 out_valid  output  1  outputs valid.
REQ-012 out0_r, out0_i, out1_r, out1_i  output  N each  results X0, X1.
REQ-013 ovf  output  1  sticky saturation flag.

Function
REQ-014 X0 = sat(scl(a+b)); X1 = sat(scl(a-b)) * conj(W), i.e. re = dr*wr + di*wi, im = di*wr - dr*wi.
REQ-015 Latency SHALL be fixed at 4: in_valid at edge t gives out_valid with data after edge t+4; throughput 1 per cycle.
REQ-016 S1: a+b and a-b computed at N+1 bits; register them, scale, and W.
REQ-017 S2: if scale, result = (x+1)>>>1 (round half up); else x; then saturate to N bits (max 2^(N-1)-1, min -2^(N-1)).
REQ-018 S3: four products, each (A*B)>>>Q truncated to N bits, registered 1 cycle; sum path and X0 delayed to match.
REQ-019 S4: re/im add/sub at N+1 bits, saturated to N bits, registered to outputs.
REQ-020 out_valid SHALL be in_valid delayed exactly 4 cycles; gaps preserved bit-for-bit.
REQ-021 Stage data registers load only when their stage valid is 1; outputs hold their last value while out_valid=0.
REQ-022 ovf SHALL set on the edge a valid sample saturates in S2 or S4; it stays set until ovf_clr.
REQ-023 ovf_clr and a new saturation in the same cycle: ovf SHALL remain 1 (set wins).
REQ-024 With scale=1, S2 SHALL never saturate (rounded range fits N bits).

Reset
REQ-025 On rst: all stage valids, out_valid, ovf = 0; all data outputs = 0; effective on the same edge.
REQ-026 Reset mid-stream SHALL discard in-flight samples; no out_valid follows for samples accepted before reset.
REQ-027 in_valid asserted during the rst cycle SHALL be ignored.

Structure
REQ-028 Shared package: LATENCY=4 constant, saturation min/max constants as functions of N.
REQ-029 The fixed-point product SHALL reuse the existing multiplier sub-module (params N, Q, ports clk, rst, A, B, C; 1-cycle registered) ×4.
REQ-030 No additional sub-modules; saturation logic is inline.

Verification (Q=15, N=16)
REQ-031 a=(0x2000,0), b=(0x1000,0), W=(0x7FFF,0), scale=0 -> at t+4: out0=(0x3000,0), out1=(0x0FFF,0), ovf=0.
REQ-032 a=(0x1000,0), b=(0,0), W=(0,0x7FFF) -> out0=(0x1000,0), out1=(0x0000,0xF001).
REQ-033 a=b=(0x7000,0), scale=0 -> out0_r=0x7FFF, ovf=1 at t+2 and held; repeat with scale=1 -> out0_r=0x7000, ovf unchanged.
REQ-034 in_valid pattern 1,1,0,1,1,1,0,1 -> out_valid reproduces the identical pattern 4 cycles later, data in order.
REQ-035 3 samples in flight, rst for one cycle -> out_valid=0 and outputs=0 after the edge, no later outputs, ovf=0.
REQ-036 ovf=1; ovf_clr=1 with a saturating sample in the same cycle -> ovf stays 1; ovf_clr alone -> ovf=0 next cycle.

Source files
------------

// File: rtl/ibutterfly2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibutterfly2_pkg
//  Description : Shared constants and helpers for the inverse radix-2
//                butterfly: pipeline depth, product lane indices and
//                two's-complement saturation limits as functions of width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ibutterfly2_pkg;

    // Input-to-output pipeline depth in clock cycles.
    localparam int LATENCY = 4;

    // Number of fixed-point multipliers and their lane assignment.
    localparam int c_num_mult = 4;
    localparam int c_p_rr     = 0;   // dr * wr
    localparam int c_p_ii     = 1;   // di * wi
    localparam int c_p_ir     = 2;   // di * wr
    localparam int c_p_ri     = 3;   // dr * wi

    // Largest positive value representable in an n-bit two's-complement word.
    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    // Most negative value representable in an n-bit two's-complement word.
    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibutterfly2_mult.sv
`default_nettype none
// ============================================================================
//  Module      : ibutterfly2_mult
//  Description : Registered signed fixed-point multiplier.
//                C = (A * B) >>> Q, truncated to N bits, one cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibutterfly2_mult
    import ibutterfly2_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] C
);

    // Operands sign-extended to the full product width so the multiply
    // is exact before the fractional bits are dropped.
    logic signed [2*N-1:0] w_a;
    logic signed [2*N-1:0] w_b;
    logic signed [2*N-1:0] w_prod;

    assign w_a    = {{N{A[N-1]}}, A};
    assign w_b    = {{N{B[N-1]}}, B};
    assign w_prod = w_a * w_b;

    // Drop Q fractional bits (floor) and keep the low N bits (wraps, no saturation).
    always_ff @(posedge clk) begin
        if (rst) begin
            C <= '0;
        end else begin
            C <= N'(w_prod >>> Q);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibutterfly2.sv
`default_nettype none
// ============================================================================
//  Module      : ibutterfly2
//  Description : Inverse-direction radix-2 DIF butterfly with conjugate
//                twiddle. X0 = sat(scl(a+b)), X1 = sat(scl(a-b)) * conj(W).
//                Four-stage pipeline, one sample per cycle, valid tracking
//                and a sticky saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibutterfly2
    import ibutterfly2_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in0_r,
    input  logic [N-1:0] in0_i,
    input  logic [N-1:0] in1_r,
    input  logic [N-1:0] in1_i,
    input  logic [N-1:0] twiddle_r,
    input  logic [N-1:0] twiddle_i,
    input  logic         scale,
    input  logic         ovf_clr,
    output logic         out_valid,
    output logic [N-1:0] out0_r,
    output logic [N-1:0] out0_i,
    output logic [N-1:0] out1_r,
    output logic [N-1:0] out1_i,
    output logic         ovf
);

    // ------------------------------------------------------------------
    // Saturation limits at output width and at the widened compare width
    // ------------------------------------------------------------------
    localparam logic [N-1:0]        c_sat_max = N'(sat_max(N));
    localparam logic [N-1:0]        c_sat_min = N'(sat_min(N));
    localparam logic signed [N+1:0] c_lim_hi  = (N+2)'(sat_max(N));
    localparam logic signed [N+1:0] c_lim_lo  = (N+2)'(sat_min(N));

    // Clamp an (N+2)-bit signed value to N bits; MSB of result flags a clamp.
    function automatic logic [N:0] sat_n(input logic [N+1:0] x);
        if ($signed(x) > c_lim_hi) begin
            return {1'b1, c_sat_max};
        end else if ($signed(x) < c_lim_lo) begin
            return {1'b1, c_sat_min};
        end
        return {1'b0, x[N-1:0]};
    endfunction

    // Optional halving with round-half-up, evaluated one bit wider so x+1
    // cannot wrap. After halving the value always fits N bits.
    function automatic logic [N+1:0] scl(input logic [N:0] x, input logic en);
        logic [N+1:0] w_ext;
        w_ext = {x[N], x};
        if (en) begin
            return $signed(w_ext + (N+2)'(1)) >>> 1;
        end
        return w_ext;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] r_vld;      // [0]=S1 [1]=S2 [2]=S3 [3]=output

    logic [N:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;

    logic [N:0]   r_s1_sum_r, r_s1_sum_i, r_s1_dif_r, r_s1_dif_i;
    logic         r_s1_scale;
    logic [N-1:0] r_s1_w_r, r_s1_w_i;

    logic [N:0]   w_s2_x0_r, w_s2_x0_i, w_s2_d_r, w_s2_d_i;
    logic         w_s2_sat;

    logic [N-1:0] r_s2_x0_r, r_s2_x0_i, r_s2_d_r, r_s2_d_i;
    logic [N-1:0] r_s2_w_r, r_s2_w_i;

    logic [N-1:0] w_mul_a [c_num_mult];
    logic [N-1:0] w_mul_b [c_num_mult];
    logic [N-1:0] w_mul_p [c_num_mult];

    logic [N-1:0] r_s3_x0_r, r_s3_x0_i;

    logic [N+1:0] w_s4_re_sum, w_s4_im_sum;
    logic [N:0]   w_s4_re, w_s4_im;
    logic         w_s4_sat;

    // ------------------------------------------------------------------
    // Stage 1: sum and difference at N+1 bits, capture scale and twiddle
    // ------------------------------------------------------------------
    assign w_sum_r = {in0_r[N-1], in0_r} + {in1_r[N-1], in1_r};
    assign w_sum_i = {in0_i[N-1], in0_i} + {in1_i[N-1], in1_i};
    assign w_dif_r = {in0_r[N-1], in0_r} - {in1_r[N-1], in1_r};
    assign w_dif_i = {in0_i[N-1], in0_i} - {in1_i[N-1], in1_i};

    // Valid shift register; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], in_valid};
        end
    end

    // Stage 1 data registers load only on an accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sum_r <= '0;
            r_s1_sum_i <= '0;
            r_s1_dif_r <= '0;
            r_s1_dif_i <= '0;
            r_s1_scale <= 1'b0;
            r_s1_w_r   <= '0;
            r_s1_w_i   <= '0;
        end else if (in_valid) begin
            r_s1_sum_r <= w_sum_r;
            r_s1_sum_i <= w_sum_i;
            r_s1_dif_r <= w_dif_r;
            r_s1_dif_i <= w_dif_i;
            r_s1_scale <= scale;
            r_s1_w_r   <= twiddle_r;
            r_s1_w_i   <= twiddle_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: scale and saturate to N bits
    // ------------------------------------------------------------------
    // Scale/saturate the four stage-1 values and flag any clamp on a valid sample.
    always_comb begin
        w_s2_x0_r = sat_n(scl(r_s1_sum_r, r_s1_scale));
        w_s2_x0_i = sat_n(scl(r_s1_sum_i, r_s1_scale));
        w_s2_d_r  = sat_n(scl(r_s1_dif_r, r_s1_scale));
        w_s2_d_i  = sat_n(scl(r_s1_dif_i, r_s1_scale));
        w_s2_sat  = r_vld[0] & (w_s2_x0_r[N] | w_s2_x0_i[N] | w_s2_d_r[N] | w_s2_d_i[N]);
    end

    // Stage 2 registers: saturated X0 and difference, twiddle carried along.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_x0_r <= '0;
            r_s2_x0_i <= '0;
            r_s2_d_r  <= '0;
            r_s2_d_i  <= '0;
            r_s2_w_r  <= '0;
            r_s2_w_i  <= '0;
        end else if (r_vld[0]) begin
            r_s2_x0_r <= w_s2_x0_r[N-1:0];
            r_s2_x0_i <= w_s2_x0_i[N-1:0];
            r_s2_d_r  <= w_s2_d_r[N-1:0];
            r_s2_d_i  <= w_s2_d_i[N-1:0];
            r_s2_w_r  <= r_s1_w_r;
            r_s2_w_i  <= r_s1_w_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: four registered products for d * conj(W)
    // ------------------------------------------------------------------
    assign w_mul_a[c_p_rr] = r_s2_d_r;
    assign w_mul_b[c_p_rr] = r_s2_w_r;
    assign w_mul_a[c_p_ii] = r_s2_d_i;
    assign w_mul_b[c_p_ii] = r_s2_w_i;
    assign w_mul_a[c_p_ir] = r_s2_d_i;
    assign w_mul_b[c_p_ir] = r_s2_w_r;
    assign w_mul_a[c_p_ri] = r_s2_d_r;
    assign w_mul_b[c_p_ri] = r_s2_w_i;

    for (genvar g = 0; g < c_num_mult; g++) begin : g_mult
        ibutterfly2_mult #(
            .N (N),
            .Q (Q)
        ) u_mult (
            .clk (clk),
            .rst (rst),
            .A   (w_mul_a[g]),
            .B   (w_mul_b[g]),
            .C   (w_mul_p[g])
        );
    end

    // X0 delayed alongside the multiplier stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_x0_r <= '0;
            r_s3_x0_i <= '0;
        end else if (r_vld[1]) begin
            r_s3_x0_r <= r_s2_x0_r;
            r_s3_x0_i <= r_s2_x0_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: conjugate combine, saturate, register outputs
    // ------------------------------------------------------------------
    // re = dr*wr + di*wi, im = di*wr - dr*wi, then clamp to N bits.
    always_comb begin
        w_s4_re_sum = {{2{w_mul_p[c_p_rr][N-1]}}, w_mul_p[c_p_rr]}
                    + {{2{w_mul_p[c_p_ii][N-1]}}, w_mul_p[c_p_ii]};
        w_s4_im_sum = {{2{w_mul_p[c_p_ir][N-1]}}, w_mul_p[c_p_ir]}
                    - {{2{w_mul_p[c_p_ri][N-1]}}, w_mul_p[c_p_ri]};
        w_s4_re     = sat_n(w_s4_re_sum);
        w_s4_im     = sat_n(w_s4_im_sum);
        w_s4_sat    = r_vld[2] & (w_s4_re[N] | w_s4_im[N]);
    end

    // Output registers hold their last value between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_r <= '0;
            out0_i <= '0;
            out1_r <= '0;
            out1_i <= '0;
        end else if (r_vld[2]) begin
            out0_r <= r_s3_x0_r;
            out0_i <= r_s3_x0_i;
            out1_r <= w_s4_re[N-1:0];
            out1_i <= w_s4_im[N-1:0];
        end
    end

    assign out_valid = r_vld[LATENCY-1];

    // Sticky overflow: a new clamp takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (w_s2_sat | w_s4_sat) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire
